// File: rtl/sort_ctrl_if.sv
// Host stream and drom port bundle for sort_ctrl.
// The slave modport is the controller's view; the master modport is the host/drom side.
interface sort_ctrl_if #(
  parameter int DW  = 4,
  parameter int AW  = 3,
  parameter int SCW = 5
);
  logic           start;
  logic           load_valid;
  logic [DW-1:0]  load_data;
  logic           load_ready;
  logic [DW-1:0]  d0, d1, d2, d3, d4, d5, d6, d7;
  logic           we;
  logic [AW-1:0]  wa;
  logic [DW-1:0]  wd;
  logic           busy;
  logic           done;
  logic [SCW-1:0] swap_cnt;

  modport master (
    output start, load_valid, load_data, d0, d1, d2, d3, d4, d5, d6, d7,
    input  load_ready, we, wa, wd, busy, done, swap_cnt
  );

  modport slave (
    input  start, load_valid, load_data, d0, d1, d2, d3, d4, d5, d6, d7,
    output load_ready, we, wa, wd, busy, done, swap_cnt
  );
endinterface

// File: rtl/sort_ctrl.sv
// Load-then-bubble-sort sequencer for the 8-entry drom register file.
// Compares one adjacent pair per cycle from drom's parallel outputs; a swap costs two write cycles.
module sort_ctrl #(
  parameter int DW  = 4,
  parameter int AW  = 3,
  parameter int SCW = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  sort_ctrl_if.slave   bus
);
  localparam int DEPTH = 2 ** AW;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CMP   = 3'd2,
    SWAP1 = 3'd3,
    SWAP2 = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t         state;
  logic [AW-1:0]  idx;
  logic           swapped;
  logic [DW-1:0]  tmp;
  logic [SCW-1:0] swap_cnt;

  logic [DW-1:0]  d [8];
  logic [AW-1:0]  idx_p1;
  logic [DW-1:0]  lo_val;
  logic [DW-1:0]  hi_val;
  logic           last_pair;
  logic           last_beat;

  assign d[0] = bus.d0;
  assign d[1] = bus.d1;
  assign d[2] = bus.d2;
  assign d[3] = bus.d3;
  assign d[4] = bus.d4;
  assign d[5] = bus.d5;
  assign d[6] = bus.d6;
  assign d[7] = bus.d7;

  assign idx_p1    = idx + 1'b1;
  assign lo_val    = d[idx];
  assign hi_val    = d[idx_p1];
  assign last_pair = (idx == AW'(DEPTH - 2));
  assign last_beat = (idx == AW'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      swapped  <= 1'b0;
      tmp      <= '0;
      swap_cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state    <= LOAD;
            idx      <= '0;
            swap_cnt <= '0;
          end
        end
        LOAD: begin
          if (bus.load_valid) begin
            if (last_beat) begin
              state   <= CMP;
              idx     <= '0;
              swapped <= 1'b0;
            end else begin
              idx <= idx_p1;
            end
          end
        end
        CMP: begin
          if (lo_val > hi_val) begin
            tmp   <= lo_val;
            state <= SWAP1;
          end else if (!last_pair) begin
            idx <= idx_p1;
          end else if (swapped) begin
            idx     <= '0;
            swapped <= 1'b0;
          end else begin
            state <= DONE;
          end
        end
        SWAP1: state <= SWAP2;
        SWAP2: begin
          state <= CMP;
          if (swap_cnt != '1) swap_cnt <= swap_cnt + 1'b1;
          // A swap on the last pair always forces another pass
          if (last_pair) begin
            idx     <= '0;
            swapped <= 1'b0;
          end else begin
            idx     <= idx_p1;
            swapped <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.we = 1'b0;
    bus.wa = '0;
    bus.wd = '0;
    case (state)
      LOAD: begin
        bus.we = bus.load_valid;
        bus.wa = idx;
        bus.wd = bus.load_data;
      end
      SWAP1: begin
        bus.we = 1'b1;
        bus.wa = idx;
        bus.wd = hi_val;
      end
      SWAP2: begin
        bus.we = 1'b1;
        bus.wa = idx_p1;
        bus.wd = tmp;
      end
      default: ;
    endcase
  end

  assign bus.load_ready = (state == LOAD);
  assign bus.busy       = (state == LOAD) || (state == CMP) || (state == SWAP1) || (state == SWAP2);
  assign bus.done       = (state == DONE);
  assign bus.swap_cnt   = swap_cnt;
endmodule

// File: tb/tb_sort_ctrl.sv
// Directed bench for sort_ctrl with a behavioural 8-entry drom attached.
module tb_sort_ctrl;
  localparam int DW  = 4;
  localparam int AW  = 3;
  localparam int SCW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sort_ctrl_if #(.DW(DW), .AW(AW), .SCW(SCW)) bus ();

  sort_ctrl #(.DW(DW), .AW(AW), .SCW(SCW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // drom model: write captured on the rising edge, contents never cleared
  logic [DW-1:0] mem [8];
  always @(posedge clk) if (bus.we) mem[bus.wa] <= bus.wd;

  assign bus.d0 = mem[0];
  assign bus.d1 = mem[1];
  assign bus.d2 = mem[2];
  assign bus.d3 = mem[3];
  assign bus.d4 = mem[4];
  assign bus.d5 = mem[5];
  assign bus.d6 = mem[6];
  assign bus.d7 = mem[7];

  int n_checks = 0;
  int n_fail   = 0;
  int sort_writes = 0;

  always @(posedge clk) if (rst_n && bus.we && bus.busy && !bus.load_ready) sort_writes <= sort_writes + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic start_job();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // beat k takes nibble k of data; vpat bit (cycle mod 16) is load_valid
  task automatic load_beats(input string tag, input logic [31:0] data, input logic [15:0] vpat);
    int k = 0;
    int cyc = 0;
    logic v;
    while (k < 8 && cyc < 40) begin
      @(negedge clk);
      v = vpat[cyc % 16];
      bus.load_valid = v;
      bus.load_data  = data[4*k +: 4];
      #1;
      check({tag, " load_ready"}, bus.load_ready, 1);
      check({tag, " we"}, bus.we, v);
      if (v) begin
        check({tag, " wa"}, bus.wa, k);
        check({tag, " wd"}, bus.wd, data[4*k +: 4]);
      end
      @(posedge clk);
      #1;
      if (v) k++;
      cyc++;
    end
    bus.load_valid = 1'b0;
    check({tag, " beats accepted"}, k, 8);
  endtask

  task automatic wait_done(input string tag);
    int c = 0;
    while (!bus.done && c < 300) begin
      @(posedge clk);
      #1;
      c++;
    end
    check({tag, " done reached"}, bus.done, 1);
  endtask

  task automatic check_mem(input string tag, input logic [31:0] exp);
    for (int i = 0; i < 8; i++) check($sformatf("%s mem[%0d]", tag, i), mem[i], exp[4*i +: 4]);
  endtask

  int w0;

  initial begin
    bus.start      = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst we", bus.we, 0);
    check("rst load_ready", bus.load_ready, 0);
    check("rst busy", bus.busy, 0);
    check("rst done", bus.done, 0);
    check("rst swap_cnt", bus.swap_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: already sorted, exact latency
    start_job();
    load_beats("t1", 32'h76543210, 16'hFFFF);
    repeat (6) @(posedge clk);
    #1;
    check("t1 done at E14", bus.done, 0);
    check("t1 busy at E14", bus.busy, 1);
    @(posedge clk);
    #1;
    check("t1 done at E15", bus.done, 1);
    check("t1 busy at E15", bus.busy, 0);
    check("t1 swap_cnt", bus.swap_cnt, 0);
    check_mem("t1", 32'h76543210);

    // 2: reverse order, worst case
    start_job();
    check("t2 restart swap_cnt", bus.swap_cnt, 0);
    load_beats("t2", 32'h01234567, 16'hFFFF);
    w0 = sort_writes;
    wait_done("t2");
    check("t2 swap_cnt", bus.swap_cnt, 28);
    check("t2 sort writes", sort_writes - w0, 56);
    check_mem("t2", 32'h76543210);

    // 3: duplicates; 13 strict inversions -> 26 writes
    start_job();
    load_beats("t3", 32'h2F0F1133, 16'hFFFF);
    w0 = sort_writes;
    wait_done("t3");
    check("t3 swap_cnt", bus.swap_cnt, 13);
    check("t3 sort writes", sort_writes - w0, 26);
    check_mem("t3", 32'hFF332110);

    // 4: stalled stream 1,0,0,1,...
    start_job();
    load_beats("t4", 32'h13572468, 16'h9999);
    wait_done("t4");
    check("t4 swap_cnt", bus.swap_cnt, 22);
    check_mem("t4", 32'h87654321);

    // 5: start ignored while sorting, honoured in DONE
    start_job();
    load_beats("t5", 32'h01234567, 16'hFFFF);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("t5 busy after start in CMP", bus.busy, 1);
    check("t5 no reload", bus.load_ready, 0);
    wait_done("t5");
    check("t5 swap_cnt", bus.swap_cnt, 28);
    check_mem("t5", 32'h76543210);
    start_job();
    check("t5 restart load_ready", bus.load_ready, 1);
    check("t5 restart done", bus.done, 0);
    check("t5 restart busy", bus.busy, 1);
    check("t5 restart swap_cnt", bus.swap_cnt, 0);

    // 6: reset during SWAP1
    load_beats("t6", 32'h76543201, 16'hFFFF);
    @(posedge clk);
    #1;
    check("t6 swap1 we", bus.we, 1);
    check("t6 swap1 wa", bus.wa, 0);
    check("t6 swap1 wd", bus.wd, 0);
    rst_n = 1'b0;
    #1;
    check("t6 rst we", bus.we, 0);
    check("t6 rst busy", bus.busy, 0);
    check("t6 rst done", bus.done, 0);
    check("t6 rst swap_cnt", bus.swap_cnt, 0);
    check("t6 rst load_ready", bus.load_ready, 0);
    @(posedge clk);
    #1;
    check("t6 mem0 kept", mem[0], 1);
    check("t6 mem1 kept", mem[1], 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("t6 idle busy", bus.busy, 0);
    check("t6 idle load_ready", bus.load_ready, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
